// File: rtl/frame_strobe_loader.sv
// Column configuration loader: assembles one frame of row data from a
// valid/ready word stream, then fires a single-cycle one-hot FrameStrobe.
module frame_strobe_loader #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 2
) (
  input  logic                                UserCLK,
  input  logic                                resetn,
  input  logic [31:0]                         cfg_data,
  input  logic                                cfg_valid,
  output logic                                cfg_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
  output logic [MaxFramesPerCol-1:0]          FrameStrobe,
  output logic                                busy,
  output logic                                err,
  output logic [15:0]                         frame_count
);

  localparam int unsigned IdxW   = 5;
  localparam int unsigned RowW   = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned DataW  = NumRows * FrameBitsPerRow;
  localparam int unsigned CountW = 16;

  localparam logic [3:0] OpWrite  = 4'hA;
  localparam logic [3:0] OpClrErr = 4'h5;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StStrobe = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  // Top row is loaded first, so the row counter starts at the highest row.
  localparam logic [RowW-1:0] RowTop = RowW'(NumRows - 1);

  logic [1:0]                 state_q,  state_d;
  logic [IdxW-1:0]            idx_q,    idx_d;
  logic [RowW-1:0]            row_q,    row_d;
  logic [DataW-1:0]           data_q,   data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       ready_q,  ready_d;
  logic                       busy_q,   busy_d;
  logic                       err_q,    err_d;
  logic [CountW-1:0]          count_q,  count_d;
  logic                       accept_c;

  assign accept_c = cfg_valid & ready_q;

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    row_d    = row_q;
    data_d   = data_q;
    strobe_d = '0;
    err_d    = err_q;
    count_d  = count_q;

    case (state_q)
      StIdle: begin
        if (accept_c) begin
          case (cfg_data[31:28])
            OpWrite: begin
              if (32'(cfg_data[IdxW-1:0]) < MaxFramesPerCol) begin
                idx_d   = cfg_data[IdxW-1:0];
                row_d   = RowTop;
                state_d = StLoad;
              end else begin
                err_d = 1'b1;
              end
            end
            OpClrErr: err_d = 1'b0;
            default:  err_d = 1'b1;
          endcase
        end
      end

      StLoad: begin
        if (accept_c) begin
          for (int r = 0; r < int'(NumRows); r++) begin
            if (row_q == RowW'(r)) begin
              data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = FrameBitsPerRow'(cfg_data);
            end
          end
          if (row_q == '0) begin
            state_d  = StStrobe;
            strobe_d = MaxFramesPerCol'(1) << idx_q;
            count_d  = count_q + CountW'(1);
          end else begin
            row_d = row_q - RowW'(1);
          end
        end
      end

      StStrobe: state_d = StHold;
      StHold:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle) || (state_d == StLoad);
    busy_d  = (state_d != StIdle);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      row_q    <= '0;
      data_q   <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      row_q    <= row_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  assign cfg_ready   = ready_q;
  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_strobe_loader.sv
// Directed bench for frame_strobe_loader with a strobe monitor and a
// scoreboard for the randomized-valid streaming run.
module tb_frame_strobe_loader;

  logic        clk;
  logic        resetn;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] FrameData;
  logic [19:0] FrameStrobe;
  logic        busy;
  logic        err;
  logic [15:0] frame_count;

  int n_chk  = 0;
  int n_pass = 0;

  logic [19:0] mon_strobe_q[$];
  logic [63:0] mon_data_q[$];

  frame_strobe_loader dut (
    .UserCLK     (clk),
    .resetn      (resetn),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every cycle in which any strobe line is high
  always @(negedge clk) begin
    if (FrameStrobe != '0) begin
      mon_strobe_q.push_back(FrameStrobe);
      mon_data_q.push_back(FrameData);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Present a word with valid held high until it is accepted
  task automatic send(input logic [31:0] w);
    logic rdy;
    bit   done;
    done      = 1'b0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      rdy = cfg_ready;
      step();
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $error("FAIL accept_timeout: word %h not accepted, expected acceptance", w);
    end
  endtask

  // Present a word with valid randomly toggled until it is accepted
  task automatic send_rand(input logic [31:0] w);
    logic rdy;
    logic v;
    bit   done;
    done     = 1'b0;
    cfg_data = w;
    for (int i = 0; i < 200 && !done; i++) begin
      cfg_valid = ($urandom_range(0, 3) != 0);
      v   = cfg_valid;
      rdy = cfg_ready;
      step();
      if (v && rdy) done = 1'b1;
    end
    cfg_valid = 1'b0;
    if (!done) begin
      n_chk++;
      $error("FAIL accept_timeout_rand: word %h not accepted, expected acceptance", w);
    end
  endtask

  initial begin
    logic [19:0] exp_strobe_q[$];
    logic [63:0] exp_data_q[$];
    logic [31:0] r1;
    logic [31:0] r0;
    logic [19:0] s;
    int          base;
    int          got;

    resetn    = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;

    // Reset values
    step();
    step();
    chk("rst_ready",  64'(cfg_ready),   64'h0);
    chk("rst_data",   FrameData,        64'h0);
    chk("rst_strobe", 64'(FrameStrobe), 64'h0);
    chk("rst_busy",   64'(busy),        64'h0);
    chk("rst_err",    64'(err),         64'h0);
    chk("rst_count",  64'(frame_count), 64'h0);
    resetn = 1'b1;
    chk("ready_before_edge", 64'(cfg_ready), 64'h0);
    step();
    chk("ready_after_edge", 64'(cfg_ready), 64'h1);

    // Single write, valid continuously high
    send(32'hA000_0003);
    chk("w1_busy", 64'(busy), 64'h1);
    send(32'h1111_1111);
    chk("w1_strobe_early", 64'(FrameStrobe), 64'h0);
    send(32'h2222_2222);
    cfg_valid = 1'b0;
    chk("w1_strobe", 64'(FrameStrobe), 64'h0_0008);
    chk("w1_data",   FrameData,        64'h1111_1111_2222_2222);
    chk("w1_count",  64'(frame_count), 64'h1);
    chk("w1_ready_strobe", 64'(cfg_ready), 64'h0);
    step();
    chk("w1_hold_strobe", 64'(FrameStrobe), 64'h0);
    chk("w1_hold_ready",  64'(cfg_ready),   64'h0);
    chk("w1_hold_busy",   64'(busy),        64'h1);
    chk("w1_hold_data",   FrameData,        64'h1111_1111_2222_2222);
    step();
    chk("w1_idle_ready", 64'(cfg_ready), 64'h1);
    chk("w1_idle_busy",  64'(busy),      64'h0);
    chk("w1_strobe_cycles", 64'(mon_strobe_q.size()), 64'h1);

    // Bubbles in LOAD, frame index 19
    send(32'hA000_0013);
    send(32'h3333_3333);
    cfg_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bub_data",   FrameData,        64'h3333_3333_2222_2222);
      chk("bub_strobe", 64'(FrameStrobe), 64'h0);
      chk("bub_busy",   64'(busy),        64'h1);
    end
    send(32'h4444_4444);
    cfg_valid = 1'b0;
    chk("bub_strobe_fire", 64'(FrameStrobe), 64'h8_0000);
    chk("bub_final_data",  FrameData,        64'h3333_3333_4444_4444);
    chk("bub_count",       64'(frame_count), 64'h2);
    step();
    step();

    // Bad commands then CLRERR
    base = mon_strobe_q.size();
    send(32'hB000_0000);
    cfg_valid = 1'b0;
    chk("bad_op_err",  64'(err),  64'h1);
    chk("bad_op_busy", 64'(busy), 64'h0);
    send(32'hA000_0014);
    cfg_valid = 1'b0;
    chk("bad_idx_err",  64'(err),  64'h1);
    chk("bad_idx_busy", 64'(busy), 64'h0);
    step();
    chk("bad_busy_later", 64'(busy),        64'h0);
    chk("bad_ready",      64'(cfg_ready),   64'h1);
    chk("bad_data",       FrameData,        64'h3333_3333_4444_4444);
    chk("bad_count",      64'(frame_count), 64'h2);
    chk("bad_no_strobe",  64'(mon_strobe_q.size() - base), 64'h0);
    send(32'h5000_0000);
    cfg_valid = 1'b0;
    chk("clrerr", 64'(err), 64'h0);

    // Reset mid-LOAD
    send(32'hF000_0000);
    cfg_valid = 1'b0;
    chk("pre_rst_err", 64'(err), 64'h1);
    send(32'hA000_0005);
    send(32'h5555_5555);
    cfg_valid = 1'b0;
    chk("pre_rst_data", FrameData, 64'h5555_5555_4444_4444);
    #2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_ready",  64'(cfg_ready),   64'h0);
    chk("mid_rst_data",   FrameData,        64'h0);
    chk("mid_rst_strobe", 64'(FrameStrobe), 64'h0);
    chk("mid_rst_busy",   64'(busy),        64'h0);
    chk("mid_rst_err",    64'(err),         64'h0);
    chk("mid_rst_count",  64'(frame_count), 64'h0);
    base = mon_strobe_q.size();
    step();
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mid_rst_no_strobe", 64'(mon_strobe_q.size() - base), 64'h0);
    send(32'hA000_0007);
    send(32'h6666_6666);
    send(32'h7777_7777);
    cfg_valid = 1'b0;
    chk("post_rst_strobe", 64'(FrameStrobe), 64'h0_0080);
    chk("post_rst_data",   FrameData,        64'h6666_6666_7777_7777);
    chk("post_rst_count",  64'(frame_count), 64'h1);
    step();
    step();

    // Streaming: 40 frames with random valid, indices 0..19 twice
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    step();
    base = mon_strobe_q.size();
    for (int f = 0; f < 40; f++) begin
      r1 = $urandom;
      r0 = $urandom;
      s  = 20'h1 << (f % 20);
      exp_strobe_q.push_back(s);
      exp_data_q.push_back({r1, r0});
      send_rand({4'hA, 23'h0, 5'(f % 20)});
      send_rand(r1);
      send_rand(r0);
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    got = mon_strobe_q.size() - base;
    chk("stream_strobe_cycles", 64'(got), 64'd40);
    chk("stream_count", 64'(frame_count), 64'd40);
    for (int i = 0; i < 40 && i < got; i++) begin
      chk($sformatf("stream_strobe_%0d", i), 64'(mon_strobe_q[base + i]), 64'(exp_strobe_q[i]));
      chk($sformatf("stream_data_%0d", i),   mon_data_q[base + i],        exp_data_q[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
